// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run controller for the 8-bit accumulator cpu. It streams a program from a
//   loader port into instruction memory, holds the cpu in reset for
//   RST_CYCLES cycles, releases it, and counts execution cycles until the cpu
//   reports halted. It then reports done.
//
// Optional feature (compile-time macro CPU_WDOG_EN):
//   When defined, a RUN that reaches MAX_CYCLES counted cycles without a halt
//   ends in DONE with timeout=1. When undefined, timeout is held at 0 and RUN
//   lasts until cpu_halted (cycle_count saturates at all-ones).
//
// Ports:
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous active-high controller reset
//   load_valid   in   1       loader byte valid
//   load_data    in   DATA_W  loader byte (instruction)
//   load_last    in   1       final program byte, qualified by valid&ready
//   load_ready   out  1       loader byte accepted this cycle when valid
//   start        in   1       run the program currently in memory
//   cpu_halted   in   1       cpu halted flag
//   cpu_reset    out  1       drives the cpu reset pin
//   mem_we       out  1       instruction memory write enable
//   mem_addr     out  ADDR_W  instruction memory write address
//   mem_wdata    out  DATA_W  instruction memory write data
//   busy         out  1       high in LOAD, RESET_CPU, RUN
//   done         out  1       high in DONE
//   timeout      out  1       last run ended by the watchdog
//   cycle_count  out  CNT_W   RUN cycles of the last/current run
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic              cpu_halted,
  output logic              cpu_reset,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RESET_CPU = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

`ifdef CPU_WDOG_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  localparam int                RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   ptr_r, ptr_s;
  logic [RC_W-1:0]     rst_cnt_r, rst_cnt_s;
  logic [CNT_W-1:0]    cycle_count_r, cycle_count_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                timeout_r, timeout_s;
  logic                mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
  logic                load_ready_r, load_ready_s;
  logic                cpu_reset_r, cpu_reset_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                accept_s;

  // Next-state, write path, counters and decoded outputs of the next state.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    rst_cnt_s     = rst_cnt_r;
    cycle_count_s = cycle_count_r;
    timeout_s     = timeout_r;
    mem_we_s      = 1'b0;
    mem_addr_s    = mem_addr_r;
    mem_wdata_s   = mem_wdata_r;
    accept_s      = load_valid & load_ready_r;
    cnt_inc_s     = (cycle_count_r == CNT_ONES) ? cycle_count_r : cycle_count_r + 1'b1;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        // A loader byte wins over start; a new program always begins at address 0.
        if (accept_s) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = ADDR_ZERO;
          mem_wdata_s = load_data;
          ptr_s       = ADDR_ONE;
          timeout_s   = 1'b0;
          state_s     = load_last ? ST_RESET_CPU : ST_LOAD;
        end else if (start) begin
          timeout_s = 1'b0;
          state_s   = ST_RESET_CPU;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        // Pointer wraps silently; start is ignored while loading.
        if (accept_s) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = ptr_r;
          mem_wdata_s = load_data;
          ptr_s       = ptr_r + 1'b1;
          state_s     = load_last ? ST_RESET_CPU : ST_LOAD;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RESET_CPU: begin
        if (rst_cnt_r == RC_LAST) begin
          state_s = ST_RUN;
        end else begin
          rst_cnt_s = rst_cnt_r + 1'b1;
        end
      end
      ST_RUN: begin
        // The halting cycle itself is not counted.
        if (cpu_halted) begin
          state_s = ST_DONE;
        end else begin
          cycle_count_s = cnt_inc_s;
          if (WDOG_EN && (cnt_inc_s == CNT_LIMIT)) begin
            timeout_s = 1'b1;
            state_s   = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Entering RESET_CPU restarts the hold counter and the cycle count.
    if ((state_s == ST_RESET_CPU) && (state_r != ST_RESET_CPU)) begin
      rst_cnt_s     = {RC_W{1'b0}};
      cycle_count_s = {CNT_W{1'b0}};
    end else begin
      rst_cnt_s     = rst_cnt_s;
      cycle_count_s = cycle_count_s;
    end

    load_ready_s = 1'b0;
    cpu_reset_s  = 1'b1;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    case (state_s)
      ST_IDLE:      begin load_ready_s = 1'b1; cpu_reset_s = 1'b1; end
      ST_LOAD:      begin load_ready_s = 1'b1; cpu_reset_s = 1'b1; busy_s = 1'b1; end
      ST_RESET_CPU: begin cpu_reset_s  = 1'b1; busy_s = 1'b1; end
      ST_RUN:       begin cpu_reset_s  = 1'b0; busy_s = 1'b1; end
      ST_DONE:      begin load_ready_s = 1'b1; cpu_reset_s = 1'b0; done_s = 1'b1; end
      default:      begin load_ready_s = 1'b0; cpu_reset_s = 1'b1; end
    endcase
  end

  // State and output registers; reset drops any write still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ptr_r         <= {ADDR_W{1'b0}};
      rst_cnt_r     <= {RC_W{1'b0}};
      cycle_count_r <= {CNT_W{1'b0}};
      timeout_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_wdata_r   <= {DATA_W{1'b0}};
      load_ready_r  <= 1'b1;
      cpu_reset_r   <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      rst_cnt_r     <= rst_cnt_s;
      cycle_count_r <= cycle_count_s;
      timeout_r     <= timeout_s;
      mem_we_r      <= mem_we_s;
      mem_addr_r    <= mem_addr_s;
      mem_wdata_r   <= mem_wdata_s;
      load_ready_r  <= load_ready_s;
      cpu_reset_r   <= cpu_reset_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end
  end

  assign load_ready  = load_ready_r;
  assign cpu_reset   = cpu_reset_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//   Directed plus randomized bench for cpu_run_ctrl. A small RAM captures the
//   controller's writes and is compared against an array model filled from
//   the program byte index (index mod 256). Run results are predicted from
//   the halt delay chosen for the stand-in cpu: n counted cycles, or the
//   watchdog limit when CPU_WDOG_EN is defined and n reaches it.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int RSTC = 2;
  localparam int MAXC = 10;
`ifdef CPU_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        start;
  logic        cpu_halted;
  logic        cpu_reset;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram       [0:255];
  logic [7:0] mem_model [0:255];
  logic [7:0] prog      [$];

  cpu_run_ctrl #(
    .ADDR_W(8), .DATA_W(8), .CNT_W(16), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start), .cpu_halted(cpu_halted),
    .cpu_reset(cpu_reset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction RAM fed by the controller's write port.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state;
    chk("rst_cpu_reset",  32'(cpu_reset),   32'd1);
    chk("rst_busy",       32'(busy),        32'd0);
    chk("rst_done",       32'(done),        32'd0);
    chk("rst_timeout",    32'(timeout),     32'd0);
    chk("rst_count",      32'(cycle_count), 32'd0);
    chk("rst_mem_we",     32'(mem_we),      32'd0);
    chk("rst_mem_addr",   32'(mem_addr),    32'd0);
    chk("rst_mem_wdata",  32'(mem_wdata),   32'd0);
    chk("rst_load_ready", 32'(load_ready),  32'd1);
  endtask

  // Streams prog[]; each accepted byte must appear on the write port one
  // cycle later at address index mod 256.
  task automatic load_prog(input bit gaps);
    int gap;
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps && i > 0) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          load_valid = 1'b0;
          tick;
          chk("gap_mem_we", 32'(mem_we),     32'd0);
          chk("gap_ready",  32'(load_ready), 32'd1);
        end
      end
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == prog.size() - 1);
      tick;
      chk("wr_we",        32'(mem_we),    32'd1);
      chk("wr_addr",      32'(mem_addr),  32'(i % 256));
      chk("wr_data",      32'(mem_wdata), 32'(prog[i]));
      chk("load_busy",    32'(busy),      32'd1);
      chk("load_cpu_rst", 32'(cpu_reset), 32'd1);
      mem_model[i % 256] = prog[i];
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Called in the first RESET_CPU cycle; leaves the bench in RUN cycle 1.
  task automatic reset_phase;
    for (int i = 0; i < RSTC; i++) begin
      chk("hold_cpu_reset", 32'(cpu_reset),   32'd1);
      chk("hold_busy",      32'(busy),        32'd1);
      chk("hold_ready",     32'(load_ready),  32'd0);
      chk("hold_done",      32'(done),        32'd0);
      chk("hold_count",     32'(cycle_count), 32'd0);
      tick;
    end
  endtask

  // Stand-in cpu halts after n RUN cycles; predicts DONE cycle and result.
  task automatic run_cpu(input int n);
    int  exp_cycles;
    int  exp_cnt;
    bit  exp_to;
    exp_to     = WDOG && (n >= MAXC);
    exp_cnt    = exp_to ? MAXC : n;
    exp_cycles = exp_to ? MAXC : n + 1;
    for (int k = 1; k <= exp_cycles; k++) begin
      chk("run_cpu_reset", 32'(cpu_reset),   32'd0);
      chk("run_busy",      32'(busy),        32'd1);
      chk("run_done",      32'(done),        32'd0);
      chk("run_count",     32'(cycle_count), 32'(k - 1));
      cpu_halted = (k > n);
      tick;
    end
    chk("end_done",      32'(done),        32'd1);
    chk("end_busy",      32'(busy),        32'd0);
    chk("end_cpu_reset", 32'(cpu_reset),   32'd0);
    chk("end_count",     32'(cycle_count), 32'(exp_cnt));
    chk("end_timeout",   32'(timeout),     32'(exp_to));
    chk("end_ready",     32'(load_ready),  32'd1);
    tick;
    chk("hold_done_done",  32'(done),        32'd1);
    chk("hold_done_count", 32'(cycle_count), 32'(exp_cnt));
  endtask

  task automatic check_ram(input int n);
    for (int i = 0; i < n; i++) chk("ram", 32'(ram[i]), 32'(mem_model[i]));
  endtask

  task automatic pulse_start;
    start      = 1'b1;
    cpu_halted = 1'b0;
    tick;
    start = 1'b0;
    chk("start_done",    32'(done),        32'd0);
    chk("start_timeout", 32'(timeout),     32'd0);
    chk("start_count",   32'(cycle_count), 32'd0);
  endtask

  initial begin
    int len;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    start      = 1'b0;
    cpu_halted = 1'b0;
    tick;
    reset = 1'b0;
    check_reset_state();

    // Fixed four-byte program, run halting after 5 cycles, then a rerun.
    prog = {8'hD5, 8'h15, 8'hF0, 8'h00};
    load_prog(1'b0);
    reset_phase();
    run_cpu(5);
    pulse_start();
    reset_phase();
    run_cpu(5);
    check_ram(4);

    // start and a loader byte together in IDLE: the load wins.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_state();
    start      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h3C;
    tick;
    start      = 1'b0;
    load_valid = 1'b0;
    mem_model[0] = 8'h3C;
    chk("coinc_we",        32'(mem_we),     32'd1);
    chk("coinc_addr",      32'(mem_addr),   32'd0);
    chk("coinc_data",      32'(mem_wdata),  32'h3C);
    chk("coinc_ready",     32'(load_ready), 32'd1);
    chk("coinc_cpu_reset", 32'(cpu_reset),  32'd1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("load_start_ready", 32'(load_ready), 32'd1);
    chk("load_start_we",    32'(mem_we),     32'd0);

    // Reset coinciding with an accepted byte drops that write.
    load_valid = 1'b1;
    load_data  = 8'h77;
    reset      = 1'b1;
    tick;
    reset      = 1'b0;
    load_valid = 1'b0;
    check_reset_state();
    tick;
    chk("drop_ram1",   32'(ram[1]),     32'(mem_model[1]));
    chk("drop_ram0",   32'(ram[0]),     32'h3C);
    chk("idle_ready",  32'(load_ready), 32'd1);
    chk("idle_busy",   32'(busy),       32'd0);

    // 257-byte program wraps; then reset in the middle of RUN.
    prog.delete();
    for (int i = 0; i < 257; i++) prog.push_back(8'($urandom));
    load_prog(1'b1);
    reset_phase();
    check_ram(256);
    chk("wrap_ram0", 32'(ram[0]), 32'(prog[256]));
    for (int k = 1; k <= 3; k++) begin
      chk("midrun_count", 32'(cycle_count), 32'(k - 1));
      cpu_halted = 1'b0;
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_state();

    // Randomized programs and halt delays; reloads start from DONE.
    for (int it = 0; it < 8; it++) begin
      len = (it == 0) ? 1 : $urandom_range(1, 24);
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
      load_prog(1'b1);
      reset_phase();
      check_ram(len);
      run_cpu($urandom_range(0, 14));
      if ($urandom_range(0, 1) == 1) begin
        pulse_start();
        reset_phase();
        run_cpu($urandom_range(0, 14));
      end
    end

    // start alone from IDLE runs the resident program.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_state();
    pulse_start();
    reset_phase();
    run_cpu(MAXC + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
